// File: rtl/hazard_flush_unit_pkg.sv
// Shared opcode constants, FSM state encodings and register-match helper for the
// hazard/flush unit and the control unit.
package hazard_flush_unit_pkg;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_STALL1 = 1'b1
  } fsm_state_t;

  function automatic logic op_uses_rt(input logic [5:0] op);
    return (op == OP_R) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

  // $0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic rt_used);
    return (dst != 5'd0) && ((dst == rs) || (rt_used && (dst == rt)));
  endfunction

endpackage

// File: rtl/hazard_flush_unit_if.sv
// Pipeline-side bundle of the hazard/flush unit: ID/EX/MEM hazard inputs in,
// stall/flush controls and event counters out.
interface hazard_flush_unit_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       ifid_op;
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             br_taken;
  logic             idex_memread;
  logic             idex_regwrite;
  logic [4:0]       idex_dst;
  logic             exmem_memread;
  logic [4:0]       exmem_dst;
  logic             ext_flush;
  logic             pc_write;
  logic             ifid_write;
  logic             flag;
  logic             if_flush;
  logic             id_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ifid_op, ifid_rs, ifid_rt, br_taken, idex_memread, idex_regwrite,
           idex_dst, exmem_memread, exmem_dst, ext_flush,
    input  pc_write, ifid_write, flag, if_flush, id_flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  ifid_op, ifid_rs, ifid_rt, br_taken, idex_memread, idex_regwrite,
           idex_dst, exmem_memread, exmem_dst, ext_flush,
    output pc_write, ifid_write, flag, if_flush, id_flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_flush_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= {CNT_W{1'b0}};
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/hazard_flush_unit.sv
// Stall/flush control for a 5-stage pipeline with ID-stage branch resolution:
// load-use and branch-operand stalls, IF flush on taken branch/jump/external flush.
module hazard_flush_unit
  import hazard_flush_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                clk,
  input logic                reset,
  hazard_flush_unit_if.slave hz
);

  logic       is_j;
  logic       is_beq;
  logic       ex_match;
  logic       mem_match;
  logic       lu;
  logic       b_alu;
  logic       b_ld_ex;
  logic       b_ld_mem;
  logic [1:0] req_len;
  logic       stall;
  logic       flush;
  fsm_state_t state;
  fsm_state_t state_next;

  always_comb begin
    is_j      = (hz.ifid_op == OP_J);
    is_beq    = (hz.ifid_op == OP_BEQ);
    ex_match  = reg_match(hz.idex_dst, hz.ifid_rs, hz.ifid_rt, op_uses_rt(hz.ifid_op));
    mem_match = reg_match(hz.exmem_dst, hz.ifid_rs, hz.ifid_rt, op_uses_rt(hz.ifid_op));
    lu        = hz.idex_memread & ex_match;
    b_alu     = is_beq & hz.idex_regwrite & ~hz.idex_memread & ex_match;
    b_ld_ex   = is_beq & hz.idex_memread & ex_match;
    b_ld_mem  = is_beq & hz.exmem_memread & mem_match;
    // A load feeding a branch from EX needs the extra cycle through MEM.
    if (b_ld_ex) begin
      req_len = 2'd2;
    end else if (lu | b_alu | b_ld_mem) begin
      req_len = 2'd1;
    end else begin
      req_len = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = ST_RUN;
    case (state)
      ST_RUN: begin
        if (hz.ext_flush) begin
          state_next = ST_RUN;
        end else if (req_len == 2'd2) begin
          state_next = ST_STALL1;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_STALL1: state_next = ST_RUN;
      default:   state_next = ST_RUN;
    endcase
  end

  // br_taken is meaningless during a stall, so branch flushes only fire on run cycles.
  always_comb begin
    stall = 1'b0;
    flush = 1'b0;
    if (reset) begin
      stall = 1'b0;
      flush = 1'b0;
    end else if (hz.ext_flush) begin
      flush = 1'b1;
    end else if ((state == ST_STALL1) || (req_len != 2'd0)) begin
      stall = 1'b1;
    end else begin
      flush = is_j | (is_beq & hz.br_taken);
    end
    hz.pc_write   = ~stall;
    hz.ifid_write = ~stall;
    hz.flag       = stall;
    hz.if_flush   = flush;
    hz.id_flush   = hz.ext_flush;
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall),
    .count (hz.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush),
    .count (hz.flush_cnt)
  );

endmodule

// File: tb/tb_hazard_flush_unit.sv
// Bench for hazard_flush_unit: directed vector table, saturation runs and a
// randomized run against a cycle-level reference model (narrow counters).
module tb_hazard_flush_unit;
  import hazard_flush_unit_pkg::*;

  localparam int W    = 4;
  localparam int MAXC = (1 << W) - 1;

  typedef struct {
    logic       rst;
    logic       ext;
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       tk;
    logic       imr;
    logic       irw;
    logic [4:0] idst;
    logic       emr;
    logic [4:0] edst;
  } in_t;

  typedef struct {
    in_t        in;
    logic [4:0] outs;   // {pc_write, ifid_write, flag, if_flush, id_flush}
    int         scnt;
    int         fcnt;
  } vec_t;

  localparam logic [4:0] O_RUN   = 5'b11000;
  localparam logic [4:0] O_STALL = 5'b00100;
  localparam logic [4:0] O_FL    = 5'b11010;
  localparam logic [4:0] O_EXT   = 5'b11011;
  localparam logic [4:0] O_RSTX  = 5'b11001;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;
  vec_t vecs[$];

  hazard_flush_unit_if #(.CNT_W(W)) hz ();

  hazard_flush_unit #(.CNT_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  function automatic in_t mk(logic rst, logic ext, logic [5:0] op, int rs, int rt, logic tk,
                             logic imr, logic irw, int idst, logic emr, int edst);
    in_t v;
    v.rst = rst; v.ext = ext; v.op = op; v.rs = 5'(rs); v.rt = 5'(rt); v.tk = tk;
    v.imr = imr; v.irw = irw; v.idst = 5'(idst); v.emr = emr; v.edst = 5'(edst);
    return v;
  endfunction

  task automatic apply(input in_t v);
    reset            = v.rst;
    hz.ext_flush     = v.ext;
    hz.ifid_op       = v.op;
    hz.ifid_rs       = v.rs;
    hz.ifid_rt       = v.rt;
    hz.br_taken      = v.tk;
    hz.idex_memread  = v.imr;
    hz.idex_regwrite = v.irw;
    hz.idex_dst      = v.idst;
    hz.exmem_memread = v.emr;
    hz.exmem_dst     = v.edst;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [4:0] dut_outs();
    return {hz.pc_write, hz.ifid_write, hz.flag, hz.if_flush, hz.id_flush};
  endfunction

  task automatic add(input in_t v, input logic [4:0] o, input int s, input int f);
    vec_t e;
    e.in = v; e.outs = o; e.scnt = s; e.fcnt = f;
    vecs.push_back(e);
  endtask

  // Extra stall cycles a fresh ID instruction needs, straight from the hazard rules.
  function automatic int need(in_t v);
    bit beq = (v.op == OP_BEQ);
    bit urt = (v.op == OP_R) || (v.op == OP_SW) || (v.op == OP_BEQ);
    bit exm = (v.idst != 0) && ((v.idst == v.rs) || (urt && (v.idst == v.rt)));
    bit mem = (v.edst != 0) && ((v.edst == v.rs) || (urt && (v.edst == v.rt)));
    if (beq && v.imr && exm) return 2;
    if ((v.imr && exm) || (beq && v.irw && !v.imr && exm) || (beq && v.emr && mem)) return 1;
    return 0;
  endfunction

  initial begin : main
    in_t nop, v;
    int  pend, ms, mf;
    logic [5:0] ops [6];
    logic [4:0] eo;
    bit  st, fl;

    nop = mk(1'b0, 1'b0, OP_R, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    v = nop; v.rst = 1'b1;
    apply(v);
    repeat (2) @(negedge clk);

    add(mk(1, 1, OP_R,   0, 0, 0, 0, 0, 0, 0, 0), O_RSTX,  0, 0);
    add(mk(0, 0, OP_R,   8, 9, 0, 1, 1, 8, 0, 0), O_STALL, 0, 0);  // load-use
    add(mk(0, 0, OP_R,   8, 9, 0, 0, 0, 0, 0, 0), O_RUN,   1, 0);
    add(mk(0, 0, OP_BEQ, 8, 9, 0, 1, 1, 8, 0, 0), O_STALL, 1, 0);  // load -> beq
    add(mk(0, 0, OP_BEQ, 8, 9, 1, 0, 0, 0, 1, 8), O_STALL, 2, 0);  // STALL1, taken ignored
    add(mk(0, 0, OP_BEQ, 8, 9, 1, 0, 0, 0, 0, 0), O_FL,    3, 0);
    add(nop,                                      O_RUN,   3, 1);
    add(mk(0, 0, OP_BEQ, 1, 9, 1, 0, 1, 9, 0, 0), O_STALL, 3, 1);  // ALU -> beq
    add(nop,                                      O_RUN,   4, 1);
    add(mk(0, 0, OP_R,   0, 0, 0, 1, 1, 0, 0, 0), O_RUN,   4, 1);  // $0 never matches
    add(mk(0, 0, OP_LW,  1, 5, 0, 1, 1, 5, 0, 0), O_RUN,   4, 1);  // LW ignores rt
    add(mk(0, 0, OP_SW,  1, 5, 0, 1, 1, 5, 0, 0), O_STALL, 4, 1);  // SW uses rt
    add(mk(0, 0, OP_J,   0, 0, 0, 0, 0, 0, 0, 0), O_FL,    5, 1);
    add(nop,                                      O_RUN,   5, 2);
    add(mk(0, 0, OP_BEQ, 8, 9, 0, 1, 1, 8, 0, 0), O_STALL, 5, 2);
    add(mk(0, 1, OP_R,   0, 0, 0, 0, 0, 0, 0, 0), O_EXT,   6, 2);  // ext aborts STALL1
    add(nop,                                      O_RUN,   6, 3);
    add(mk(0, 0, OP_BEQ, 8, 9, 0, 1, 1, 8, 0, 0), O_STALL, 6, 3);
    add(mk(1, 0, OP_R,   0, 0, 0, 0, 0, 0, 0, 0), O_RUN,   7, 3);  // reset in STALL1
    add(nop,                                      O_RUN,   0, 0);
    add(mk(0, 1, OP_R,   8, 9, 0, 1, 1, 8, 0, 0), O_EXT,   0, 0);  // ext beats load-use
    add(nop,                                      O_RUN,   0, 1);

    foreach (vecs[i]) begin
      @(negedge clk);
      apply(vecs[i].in);
      #1;
      chk($sformatf("row%0d outs", i), int'(dut_outs()), int'(vecs[i].outs));
      chk($sformatf("row%0d stall_cnt", i), int'(hz.stall_cnt), vecs[i].scnt);
      chk($sformatf("row%0d flush_cnt", i), int'(hz.flush_cnt), vecs[i].fcnt);
    end

    // Saturation: hold a load-use hazard, then a jump, past the counter range.
    @(negedge clk);
    v = nop; v.rst = 1'b1;
    apply(v);
    for (int i = 0; i <= MAXC + 2; i++) begin
      @(negedge clk);
      apply(mk(0, 0, OP_R, 8, 9, 0, 1, 1, 8, 0, 0));
      #1;
      chk($sformatf("sat stall i%0d", i), int'(hz.stall_cnt), (i < MAXC) ? i : MAXC);
    end
    for (int i = 0; i <= MAXC + 2; i++) begin
      @(negedge clk);
      apply(mk(0, 0, OP_J, 0, 0, 0, 0, 0, 0, 0, 0));
      #1;
      chk($sformatf("sat flush i%0d", i), int'(hz.flush_cnt), (i < MAXC) ? i : MAXC);
      chk($sformatf("sat hold i%0d", i), int'(hz.stall_cnt), MAXC);
    end

    // Randomized run against the reference model.
    ops[0] = OP_R; ops[1] = OP_J; ops[2] = OP_LW; ops[3] = OP_SW; ops[4] = OP_BEQ; ops[5] = 6'b001000;
    pend = 0; ms = MAXC; mf = MAXC;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      v.rst  = (i == 0) || ($urandom_range(0, 29) == 0);
      v.ext  = ($urandom_range(0, 9) == 0);
      v.op   = ops[$urandom_range(0, 5)];
      v.rs   = 5'($urandom_range(0, 3));
      v.rt   = 5'($urandom_range(0, 3));
      v.tk   = 1'($urandom_range(0, 1));
      v.imr  = 1'($urandom_range(0, 1));
      v.irw  = v.imr | 1'($urandom_range(0, 1));
      v.idst = 5'($urandom_range(0, 3));
      v.emr  = 1'($urandom_range(0, 1));
      v.edst = 5'($urandom_range(0, 3));
      apply(v);
      st = 1'b0; fl = 1'b0;
      if (v.rst) begin
        pend = 0;
      end else if (v.ext) begin
        fl = 1'b1; pend = 0;
      end else if (pend > 0) begin
        st = 1'b1; pend--;
      end else if (need(v) > 0) begin
        st = 1'b1; pend = need(v) - 1;
      end else begin
        fl = (v.op == OP_J) || ((v.op == OP_BEQ) && v.tk);
      end
      eo = {~st, ~st, st, fl, v.ext};
      #1;
      chk($sformatf("rnd%0d outs", i), int'(dut_outs()), int'(eo));
      chk($sformatf("rnd%0d stall_cnt", i), int'(hz.stall_cnt), ms);
      chk($sformatf("rnd%0d flush_cnt", i), int'(hz.flush_cnt), mf);
      if (v.rst) begin
        ms = 0; mf = 0;
      end else begin
        if (st && ms < MAXC) ms++;
        if (fl && mf < MAXC) mf++;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
